// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator with framebuffer prefetch.
// Produces H/V sync from a divided pixel tick, keeps a small pixel FIFO
// topped up through a request/response read port, and drives RGB from the
// FIFO head during the active area. The FIFO is flushed and the fetch
// address rewound once per frame, on the last line, so every frame starts
// reading from pixel 0. Reads still in flight at that point are dropped
// when they return.
module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIX_DIV    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              reset,
  output logic              oFbReqValid,
  output logic [ADDR_W-1:0] oFbReqAddr,
  input  logic              iFbReqReady,
  input  logic              iFbRspValid,
  input  logic [11:0]       iFbRspData,
  output logic [3:0]        oRed,
  output logic [3:0]        oGreen,
  output logic [3:0]        oBlue,
  output logic              oHs,
  output logic              oVs,
  output logic              oFrameStart,
  output logic              oUnderflow
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PIX_TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int DW        = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int PW        = $clog2(FIFO_DEPTH);
  // FIFO occupancy and outstanding reads both range 0..FIFO_DEPTH
  localparam int CW        = PW + 1;
  // stale reads can span one frame's worth of outstanding plus leftovers
  localparam int XW        = CW + 1;

  localparam logic [DW-1:0]     DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]     H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]     HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]     HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]     V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]     VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]     VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] PIX_LIM  = ADDR_W'(PIX_TOTAL);
  localparam logic [CW:0]       DEPTH_L  = (CW+1)'(FIFO_DEPTH);

  // timing state
  logic [DW-1:0]     r_divcnt;
  logic [HW-1:0]     r_hcnt;
  logic [VW-1:0]     r_vcnt;

  // fetch state
  logic [ADDR_W-1:0] r_addr;
  logic [CW-1:0]     r_outst;
  logic [XW-1:0]     r_discard;

  // pixel FIFO
  logic [11:0]       r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  // registered outputs
  logic [11:0]       r_rgb;
  logic              r_hs;
  logic              r_vs;
  logic              r_fs;
  logic              r_uf;

  logic              w_tick;
  logic              w_active;
  logic              w_hs_n;
  logic              w_vs_n;
  logic              w_resync;
  logic              w_empty;
  logic              w_pop;
  logic              w_req_valid;
  logic              w_accept;
  logic              w_rsp_drop;
  logic              w_rsp_keep;
  logic              w_push;
  logic [CW:0]       w_inflight;
  logic [XW-1:0]     w_stale_total;

  assign w_tick     = (r_divcnt == DIV_LAST);
  assign w_active   = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_hs_n     = !((r_hcnt >= HS_BEG) && (r_hcnt < HS_END));
  assign w_vs_n     = !((r_vcnt >= VS_BEG) && (r_vcnt < VS_END));
  // Resync lands on the first pixel of the last (blank) line, leaving a
  // whole line of time to refill the FIFO before pixel (0,0).
  assign w_resync   = w_tick && (r_vcnt == V_LAST) && (r_hcnt == '0);
  assign w_empty    = (r_count == '0);
  assign w_pop      = w_tick && w_active && !w_empty;

  // Requests are throttled so that every outstanding read already owns a
  // FIFO slot; responses can therefore never overflow the FIFO. The request
  // is dropped on the resync cycle so nothing is accepted as the address
  // rewinds. Once raised it only falls on acceptance: a pop can only shrink
  // the occupancy sum, and a push trades an outstanding read for an entry.
  assign w_inflight  = {1'b0, r_count} + {1'b0, r_outst};
  assign w_req_valid = !reset && (r_addr < PIX_LIM) && (w_inflight < DEPTH_L) && !w_resync;
  assign w_accept    = w_req_valid && iFbReqReady;

  // Responses are in order, so the oldest r_discard of them are the stale ones.
  assign w_rsp_drop  = iFbRspValid && (r_discard != '0);
  assign w_rsp_keep  = iFbRspValid && (r_discard == '0);
  assign w_push      = w_rsp_keep && !w_resync;

  // Everything still in flight at resync belongs to the old frame; the
  // response landing on that very cycle is discarded too.
  assign w_stale_total = r_discard + XW'(r_outst);

  assign oFbReqValid = w_req_valid;
  assign oFbReqAddr  = r_addr;
  assign oRed        = r_rgb[11:8];
  assign oGreen      = r_rgb[7:4];
  assign oBlue       = r_rgb[3:0];
  assign oHs         = r_hs;
  assign oVs         = r_vs;
  assign oFrameStart = r_fs;
  assign oUnderflow  = r_uf;

  // pixel divider and raster counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_divcnt <= '0;
      r_hcnt   <= '0;
      r_vcnt   <= '0;
    end else if (w_tick) begin
      r_divcnt <= '0;
      if (r_hcnt == H_LAST) begin
        r_hcnt <= '0;
        r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end else begin
      r_divcnt <= r_divcnt + 1'b1;
    end
  end

  // fetch address, outstanding reads and stale-read bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      r_outst   <= '0;
      r_discard <= '0;
    end else if (w_resync) begin
      r_addr    <= '0;
      r_outst   <= '0;
      r_discard <= w_stale_total - XW'(iFbRspValid && (w_stale_total != '0));
    end else begin
      if (w_accept)
        r_addr <= r_addr + 1'b1;
      r_outst <= r_outst + CW'(w_accept) - CW'(w_rsp_keep);
      if (w_rsp_drop)
        r_discard <= r_discard - 1'b1;
    end
  end

  // FIFO storage; entries need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wptr] <= iFbRspData;
  end

  // FIFO pointers and occupancy; resync empties it in one cycle
  always_ff @(posedge clk) begin
    if (reset || w_resync) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // output registers: load on the pixel tick, hold until the next one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_fs  <= 1'b0;
      r_uf  <= 1'b0;
    end else begin
      r_fs <= 1'b0;
      if (w_tick) begin
        r_hs  <= w_hs_n;
        r_vs  <= w_vs_n;
        r_fs  <= (r_hcnt == '0) && (r_vcnt == '0);
        r_rgb <= w_pop ? r_fifo[r_rptr] : 12'h000;
        // an empty FIFO on a visible pixel is latched until reset
        if (w_active && w_empty)
          r_uf <= 1'b1;
      end
    end
  end

endmodule
